training_sequencer: RTL and testbench

//  Parametrised sample sequencer for the neuron trainer. Holds a writable table of NUM_SAMPLES

---
 rtl/training_sequencer.sv | 123 ++++++++++++
 tb/tb_training_sequencer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/training_sequencer.sv
// training_sequencer: streams a writable table of training samples to a trainer over valid/ready
// for up to EPOCHS epochs, stopping early after an epoch whose returned errors were all within tolerance.
module training_sequencer #(
    parameter int          NUM_INPUTS  = 2,
    parameter int          NUM_SAMPLES = 4,
    parameter int          EPOCHS      = 5,
    parameter int          EARLY_STOP  = 1,
    parameter int unsigned ERR_TOL     = 0,
    parameter int          SIGN        = 1,
    parameter int          Q_M         = 15,
    parameter int          Q_N         = 16,
    parameter int          W           = SIGN + Q_M + Q_N,
    parameter int          AW          = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1,
    parameter int          EW          = $clog2(EPOCHS + 1)
) (
    input  logic                    clk_i,
    input  logic                    reset_ni,
    input  logic                    wr_en_i,
    input  logic [AW-1:0]           wr_addr_i,
    input  logic [NUM_INPUTS*W-1:0] wr_x_i,
    input  logic [W-1:0]            wr_y_i,
    input  logic                    start_i,
    input  logic                    abort_i,
    output logic                    s_valid_o,
    input  logic                    s_ready_i,
    output logic [NUM_INPUTS*W-1:0] s_x_o,
    output logic [W-1:0]            s_y_o,
    output logic                    s_last_o,
    input  logic                    err_valid_i,
    input  logic [W-1:0]            err_i,
    output logic [EW-1:0]           epoch_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    converged_o
);
    localparam int OW = $clog2(NUM_SAMPLES + 1);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
    logic [NUM_INPUTS*W-1:0] r_tx [NUM_SAMPLES];
    logic [W-1:0]            r_ty [NUM_SAMPLES];
    logic [1:0]              r_state;
    logic [AW-1:0]           r_idx;
    logic [OW-1:0]           r_out, r_err;
    logic [EW-1:0]           r_epoch;
    logic                    r_conv;
    logic [NUM_INPUTS*W-1:0] r_sx;
    logic [W-1:0]            r_sy;
    logic                    w_hs, w_act, w_ret, w_bad, w_last, w_drained, w_stop;
    logic [W-1:0]            w_neg, w_abs;
    logic [OW-1:0]           w_out_n, w_err_n;
    logic [AW-1:0]           w_nidx;
    always_comb begin
        w_hs      = r_state == S_RUN && s_ready_i;
        w_act     = r_state == S_RUN || r_state == S_DRAIN;
        w_ret     = err_valid_i && w_act && (r_out != '0 || w_hs);
        w_neg     = -err_i;
        // negating the most-negative value wraps back to negative, so clamp it to max positive
        w_abs     = !err_i[W-1] ? err_i : (w_neg[W-1] ? {1'b0, {(W-1){1'b1}}} : w_neg);
        w_bad     = w_abs > W'(ERR_TOL);
        w_out_n   = r_out + OW'(w_hs) - OW'(w_ret);
        w_err_n   = (w_ret && w_bad && r_err != '1) ? r_err + OW'(1) : r_err;
        w_last    = r_idx == AW'(NUM_SAMPLES - 1);
        w_nidx    = w_last ? '0 : r_idx + AW'(1);
        w_drained = r_state == S_DRAIN && w_out_n == '0;
        w_stop    = (EARLY_STOP != 0 && w_err_n == '0) || r_epoch + EW'(1) == EW'(EPOCHS);
    end
    always_ff @(posedge clk_i)
        if (wr_en_i && r_state == S_IDLE && {1'b0, wr_addr_i} < (AW+1)'(NUM_SAMPLES)) begin
            r_tx[wr_addr_i] <= wr_x_i;
            r_ty[wr_addr_i] <= wr_y_i;
        end
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_out   <= '0;
            r_err   <= '0;
            r_epoch <= '0;
            r_conv  <= 1'b0;
            r_sx    <= '0;
            r_sy    <= '0;
        end else if (abort_i) begin
            r_state <= S_IDLE;
        end else begin
            r_out <= w_out_n;
            r_err <= w_err_n;
            if (r_state == S_IDLE && start_i) begin
                r_state <= S_RUN;
                r_idx   <= '0;
                r_out   <= '0;
                r_err   <= '0;
                r_epoch <= '0;
                r_conv  <= 1'b0;
                r_sx    <= r_tx[0];
                r_sy    <= r_ty[0];
            end
            if (w_hs) begin
                r_idx <= w_nidx;
                r_sx  <= r_tx[w_nidx];
                r_sy  <= r_ty[w_nidx];
                if (w_last) r_state <= S_DRAIN;
            end
            if (w_drained) begin
                r_epoch <= r_epoch + EW'(1);
                if (w_stop) begin
                    r_state <= S_DONE;
                    r_conv  <= EARLY_STOP != 0 && w_err_n == '0;
                end else begin
                    r_state <= S_RUN;
                    r_err   <= '0;
                end
            end
            if (r_state == S_DONE) r_state <= S_IDLE;
        end
    end
    assign s_valid_o   = r_state == S_RUN;
    assign s_last_o    = r_state == S_RUN && w_last;
    assign s_x_o       = r_sx;
    assign s_y_o       = r_sy;
    assign epoch_o     = r_epoch;
    assign busy_o      = r_state != S_IDLE;
    assign done_o      = r_state == S_DONE;
    assign converged_o = r_conv;
endmodule

// File: tb/tb_training_sequencer.sv
// tb_training_sequencer: directed vectors for the sample sequencer (4-row AND table, 2 epochs)
// plus a 1-row/1-epoch instance.
module tb_training_sequencer;
    localparam int W = 32, NI = 2;
    localparam logic [W-1:0] ONE = 32'h0001_0000;
    typedef struct {
        int          lat;
        logic [31:0] err;
        int          stall;
        int          exp_epoch;
        logic        exp_conv;
        int          exp_hs;
    } vec_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic              rst_n = 1'b0, wr_en = 1'b0, start = 1'b0, abort = 1'b0, s_ready = 1'b0;
    logic [1:0]        wr_addr = '0;
    logic [NI*W-1:0]   wr_x = '0;
    logic [W-1:0]      wr_y = '0, err_val = '0;
    logic              s_valid, s_last, busy, done, conv, err_valid;
    logic [NI*W-1:0]   s_x;
    logic [W-1:0]      s_y;
    logic [1:0]        epoch;
    logic              wr_en1 = 1'b0, start1 = 1'b0, s_ready1 = 1'b1;
    logic [0:0]        wr_addr1 = '0;
    logic [NI*W-1:0]   wr_x1 = '0;
    logic [W-1:0]      wr_y1 = '0;
    logic              s_valid1, s_last1, busy1, done1, conv1, err_valid1;
    logic [NI*W-1:0]   s_x1;
    logic [W-1:0]      s_y1;
    logic [0:0]        epoch1;
    int                lat = 0;
    logic [7:0]        hpipe = '0;
    logic [96:0]       log_q[$];
    int                total = 0, bad = 0;
    training_sequencer #(.NUM_INPUTS(NI), .NUM_SAMPLES(4), .EPOCHS(2), .EARLY_STOP(1), .ERR_TOL(1)) u0 (
        .clk_i(clk), .reset_ni(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_x_i(wr_x),
        .wr_y_i(wr_y), .start_i(start), .abort_i(abort), .s_valid_o(s_valid), .s_ready_i(s_ready),
        .s_x_o(s_x), .s_y_o(s_y), .s_last_o(s_last), .err_valid_i(err_valid), .err_i(err_val),
        .epoch_o(epoch), .busy_o(busy), .done_o(done), .converged_o(conv));
    training_sequencer #(.NUM_INPUTS(NI), .NUM_SAMPLES(1), .EPOCHS(1)) u1 (
        .clk_i(clk), .reset_ni(rst_n), .wr_en_i(wr_en1), .wr_addr_i(wr_addr1), .wr_x_i(wr_x1),
        .wr_y_i(wr_y1), .start_i(start1), .abort_i(1'b0), .s_valid_o(s_valid1), .s_ready_i(s_ready1),
        .s_x_o(s_x1), .s_y_o(s_y1), .s_last_o(s_last1), .err_valid_i(err_valid1), .err_i(ONE),
        .epoch_o(epoch1), .busy_o(busy1), .done_o(done1), .converged_o(conv1));
    // trainer model: one error per accepted sample, returned lat cycles later
    assign err_valid  = (lat == 0) ? (s_valid && s_ready) : hpipe[lat-1];
    assign err_valid1 = s_valid1 && s_ready1;
    always @(posedge clk) begin
        hpipe <= {hpipe[6:0], s_valid && s_ready};
        if (s_valid && s_ready) log_q.push_back({s_last, s_y, s_x});
    end
    task automatic chk(input string n, input logic [127:0] a, input logic [127:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", n, a, e);
        end
    endtask
    function automatic logic [96:0] row_exp(input int r);
        logic [W-1:0] x0, x1, y;
        x0 = (r < 2) ? ONE : '0;
        x1 = (r % 2 == 0) ? ONE : '0;
        y  = (r == 0) ? ONE : '0;
        return {r == 3, y, x1, x0};
    endfunction
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic wr0(input int a, input logic [W-1:0] x0, input logic [W-1:0] x1, input logic [W-1:0] y);
        wr_en = 1'b1; wr_addr = 2'(a); wr_x = {x1, x0}; wr_y = y;
        step();
        wr_en = 1'b0;
    endtask
    task automatic chk_order(input string n, input int base, input int cnt);
        int nmis = 0;
        chk({n, "_hs"}, 128'(log_q.size() - base), 128'(cnt));
        for (int i = 0; i < cnt && base + i < log_q.size(); i++)
            if (log_q[base+i] !== row_exp(i % 4)) nmis++;
        chk({n, "_order"}, 128'(nmis), 0);
    endtask
    task automatic wait_idle(input string n);
        int c = 0;
        while (busy && c < 300) begin step(); c++; end
        chk({n, "_timeout"}, 128'(busy), 0);
    endtask
    task automatic run_vec(input vec_t v, input int id);
        int base, nd, cyc;
        logic pv, pr;
        logic [96:0] pd;
        string n;
        n = $sformatf("vec%0d", id);
        base = log_q.size(); lat = v.lat; err_val = v.err; nd = 0;
        s_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0; pv = 1'b0; pr = 1'b0; pd = '0;
        for (cyc = 0; cyc < 400; cyc++) begin
            if (pv && !pr) chk({n, "_stall_hold"}, {s_valid, s_last, s_y, s_x}, {1'b1, pd});
            if (done) nd++;
            if (nd > 0 && !done) break;
            s_ready = v.stall != 0 ? ($urandom_range(0, 2) != 0) : 1'b1;
            pv = s_valid; pr = s_ready; pd = {s_last, s_y, s_x};
            step();
        end
        s_ready = 1'b1;
        chk({n, "_done_pulses"}, 128'(nd), 1);
        chk({n, "_epoch"}, 128'(epoch), 128'(v.exp_epoch));
        chk({n, "_conv"}, 128'(conv), 128'(v.exp_conv));
        chk({n, "_idle"}, {busy, s_valid}, 0);
        chk_order(n, base, v.exp_hs);
    endtask
    initial begin
        vec_t vecs[6];
        int base, nd, nhs;
        logic [9:0] vb;
        logic [96:0] cap;
        vecs[0] = '{0, ONE,           0, 2, 1'b0, 8};
        vecs[1] = '{0, 32'h0,         0, 1, 1'b1, 4};
        vecs[2] = '{1, 32'h8000_0000, 1, 2, 1'b0, 8};
        vecs[3] = '{2, 32'hFFFF_FFFF, 1, 1, 1'b1, 4};
        vecs[4] = '{3, 32'h2,         0, 2, 1'b0, 8};
        vecs[5] = '{0, 32'h1,         1, 1, 1'b1, 4};
        repeat (3) step();
        chk("rst_valid_last", {s_valid, s_last}, 0);
        chk("rst_data", {s_x, s_y}, 0);
        chk("rst_status", {epoch, busy, done, conv}, 0);
        chk("rst_u1", {s_valid1, busy1, done1, conv1, epoch1}, 0);
        rst_n = 1'b1;
        step();
        for (int r = 0; r < 4; r++) begin
            logic [96:0] e;
            e = row_exp(r);
            wr0(r, e[W-1:0], e[2*W-1:W], e[3*W-1:2*W]);
        end
        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);
        // late errors hold DRAIN; write and start mid-run must be ignored
        base = log_q.size(); lat = 3; err_val = 32'h2; s_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            vb[i] = s_valid;
            if (i == 1) begin
                wr_en = 1'b1; wr_addr = 2'd0; wr_x = '1; wr_y = '1; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            if (i == 5) chk("late_epoch_before", 128'(epoch), 0);
            if (i == 6) chk("late_epoch_after", 128'(epoch), 1);
        end
        chk("late_valid_pattern", 128'(vb), 128'(10'b1111000111));
        wait_idle("late");
        chk("late_epoch_end", {epoch, conv}, {2'd2, 1'b0});
        chk_order("late", base, 8);
        // abort while sample 2 of epoch 1 is presented
        lat = 0; err_val = 32'h2; s_ready = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("abort_presented", {s_valid, s_last, s_y, s_x}, {1'b1, row_exp(2)});
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_stop", {s_valid, busy}, 0);
        chk("abort_epoch", 128'(epoch), 0);
        nd = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) nd++;
            step();
        end
        chk("abort_no_done", 128'(nd), 0);
        run_vec(vecs[0], 6);
        // single sample, single epoch; row 1 is out of range and must be dropped
        wr_en1 = 1'b1; wr_addr1 = 1'b0; wr_x1 = {32'h0, ONE}; wr_y1 = ONE;
        step();
        wr_addr1 = 1'b1; wr_x1 = '1; wr_y1 = '1;
        step();
        wr_en1 = 1'b0; start1 = 1'b1;
        step();
        start1 = 1'b0; nd = 0; nhs = 0; cap = '0;
        for (int c = 0; c < 50; c++) begin
            if (s_valid1 && s_ready1) begin nhs++; cap = {s_last1, s_y1, s_x1}; end
            if (done1) nd++;
            if (nd > 0 && !done1) break;
            step();
        end
        chk("one_hs", 128'(nhs), 1);
        chk("one_sample", 128'(cap), {1'b1, ONE, 32'h0, ONE});
        chk("one_done", 128'(nd), 1);
        chk("one_status", {epoch1, conv1, busy1}, {1'b1, 1'b0, 1'b0});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
